// File: rtl/decoding_graph_controller.sv
// Controller for the single-FPGA decoding graph: runs one syndrome frame through LOAD/GROW/MERGE
// iterations, then streams the snapshotted per-PU root table out over a valid/ready port.
module decoding_graph_controller #(
    parameter int CODE_DISTANCE_X  = 3,
    parameter int CODE_DISTANCE_Z  = 2,
    parameter int STAGE_WIDTH      = 3,
    parameter int MAX_GROW_ITER    = 16,
    parameter int MERGE_MIN_CYCLES = 2,
    localparam int ROUNDS          = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z,
    localparam int ADDRESS_WIDTH   = 3 * $clog2(ROUNDS),
    localparam int PU_COUNT        = CODE_DISTANCE_X * CODE_DISTANCE_Z * ROUNDS,
    localparam int IDX_W           = $clog2(PU_COUNT),
    localparam int ITER_W          = $clog2(MAX_GROW_ITER + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              syndrome_valid,
    output logic                              syndrome_ready,
    input  logic [PU_COUNT-1:0]               syndrome,
    output logic [STAGE_WIDTH-1:0]            stage,
    output logic                              global_stage,
    output logic [PU_COUNT-1:0]               measurements,
    input  logic                              graph_busy,
    input  logic                              graph_odd,
    input  logic [ADDRESS_WIDTH*PU_COUNT-1:0] graph_roots,
    output logic                              root_valid,
    input  logic                              root_ready,
    output logic [ADDRESS_WIDTH-1:0]          root_data,
    output logic [IDX_W-1:0]                  root_index,
    output logic                              root_last,
    output logic [ITER_W-1:0]                 iterations,
    output logic                              timeout
);

    localparam int DWELL_W = $clog2(MERGE_MIN_CYCLES + 1);
    localparam logic [DWELL_W-1:0]     DWELL_MAX    = DWELL_W'(MERGE_MIN_CYCLES);
    localparam logic [DWELL_W-1:0]     DWELL_LAST   = DWELL_W'(MERGE_MIN_CYCLES - 1);
    localparam logic [ITER_W-1:0]      ITER_MAX     = ITER_W'(MAX_GROW_ITER);
    localparam logic [IDX_W-1:0]       IDX_LAST     = IDX_W'(PU_COUNT - 1);
    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE   = STAGE_WIDTH'(0);
    localparam logic [STAGE_WIDTH-1:0] STAGE_LOAD   = STAGE_WIDTH'(1);
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROW   = STAGE_WIDTH'(2);
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE  = STAGE_WIDTH'(3);
    localparam logic [STAGE_WIDTH-1:0] STAGE_REPORT = STAGE_WIDTH'(4);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_GROW   = 3'd2,
        S_MERGE  = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t                                   state;
    logic [DWELL_W-1:0]                       dwell;
    logic [PU_COUNT-1:0][ADDRESS_WIDTH-1:0]   roots_snap;
    logic [IDX_W-1:0]                         next_index;

    assign syndrome_ready = (state == S_IDLE);
    assign root_last      = (root_index == IDX_LAST);
    assign next_index     = root_index + 1'b1;

    // NOTE: every register below is assigned with <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            stage        <= STAGE_IDLE;
            global_stage <= 1'b0;
            measurements <= '0;
            dwell        <= '0;
            // NOTE: the root snapshot is cleared too, so a stream can never expose a previous decode's table.
            roots_snap   <= '0;
            root_valid   <= 1'b0;
            root_data    <= '0;
            root_index   <= '0;
            iterations   <= '0;
            timeout      <= 1'b0;
        end else begin
            global_stage <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (syndrome_valid) begin
                        measurements <= syndrome;
                        iterations   <= '0;
                        timeout      <= 1'b0;
                        state        <= S_LOAD;
                        stage        <= STAGE_LOAD;
                        global_stage <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state        <= S_GROW;
                    stage        <= STAGE_GROW;
                    global_stage <= 1'b1;
                end
                S_GROW: begin
                    iterations   <= iterations + 1'b1;
                    dwell        <= '0;
                    state        <= S_MERGE;
                    stage        <= STAGE_MERGE;
                    global_stage <= 1'b1;
                end
                S_MERGE: begin
                    if (dwell != DWELL_MAX) begin
                        dwell <= dwell + 1'b1;
                    end
                    // Graph status lags by a register, so it is only trusted after the minimum dwell.
                    if (dwell >= DWELL_LAST && !graph_busy) begin
                        if (graph_odd && iterations != ITER_MAX) begin
                            state        <= S_GROW;
                            stage        <= STAGE_GROW;
                            global_stage <= 1'b1;
                        end else begin
                            timeout      <= graph_odd;
                            roots_snap   <= graph_roots;
                            root_data    <= graph_roots[ADDRESS_WIDTH-1:0];
                            root_index   <= '0;
                            root_valid   <= 1'b1;
                            state        <= S_REPORT;
                            stage        <= STAGE_REPORT;
                            global_stage <= 1'b1;
                        end
                    end
                end
                S_REPORT: begin
                    if (root_valid && root_ready) begin
                        if (root_last) begin
                            root_valid   <= 1'b0;
                            root_index   <= '0;
                            state        <= S_IDLE;
                            stage        <= STAGE_IDLE;
                            global_stage <= 1'b1;
                        end else begin
                            root_index <= next_index;
                            root_data  <= roots_snap[next_index];
                        end
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    stage      <= STAGE_IDLE;
                    root_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoding_graph_controller.sv
// Randomised bench for decoding_graph_controller: a per-cycle reference model plus per-decode
// transaction checks against values derived directly from the scripted graph behaviour.
module tb_decoding_graph_controller;

    localparam int PU = 18;
    localparam int AW = 6;
    localparam int IW = 5;
    localparam int XW = 5;
    localparam int MAX_ITER = 16;
    localparam int MIN_MERGE = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            syndrome_valid = 1'b0;
    logic            syndrome_ready;
    logic [PU-1:0]   syndrome = '0;
    logic [2:0]      stage;
    logic            global_stage;
    logic [PU-1:0]   measurements;
    logic            graph_busy = 1'b0;
    logic            graph_odd = 1'b0;
    logic [AW*PU-1:0] graph_roots = '0;
    logic            root_valid;
    logic            root_ready = 1'b0;
    logic [AW-1:0]   root_data;
    logic [IW-1:0]   root_index;
    logic            root_last;
    logic [XW-1:0]   iterations;
    logic            timeout;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decoding_graph_controller #(
        .CODE_DISTANCE_X(3), .CODE_DISTANCE_Z(2), .STAGE_WIDTH(3),
        .MAX_GROW_ITER(MAX_ITER), .MERGE_MIN_CYCLES(MIN_MERGE)
    ) dut (
        .clk(clk), .reset(reset),
        .syndrome_valid(syndrome_valid), .syndrome_ready(syndrome_ready), .syndrome(syndrome),
        .stage(stage), .global_stage(global_stage), .measurements(measurements),
        .graph_busy(graph_busy), .graph_odd(graph_odd), .graph_roots(graph_roots),
        .root_valid(root_valid), .root_ready(root_ready), .root_data(root_data),
        .root_index(root_index), .root_last(root_last),
        .iterations(iterations), .timeout(timeout)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks which decode phase the controller must be in and what it must show.
    int            m_stage = 0;
    bit            m_gs = 1'b0;
    logic [PU-1:0] m_meas = '0;
    int            m_iter = 0;
    bit            m_to = 1'b0;
    bit            m_valid = 1'b0;
    int            m_idx = 0;
    int            m_merge = 0;
    logic [AW-1:0] m_roots [PU];
    int            m_prev;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_stage = 0; m_gs = 1'b0; m_meas = '0; m_iter = 0; m_to = 1'b0;
            m_valid = 1'b0; m_idx = 0; m_merge = 0;
        end else begin
            m_prev = m_stage;
            case (m_stage)
                0: if (syndrome_valid) begin
                       m_meas = syndrome; m_iter = 0; m_to = 1'b0; m_stage = 1;
                   end
                1: m_stage = 2;
                2: begin m_iter++; m_merge = 0; m_stage = 3; end
                3: begin
                    m_merge++;
                    if (m_merge >= MIN_MERGE && !graph_busy) begin
                        if (graph_odd && m_iter < MAX_ITER) m_stage = 2;
                        else begin
                            m_to = graph_odd;
                            for (int n = 0; n < PU; n++) m_roots[n] = graph_roots[n*AW +: AW];
                            m_idx = 0; m_valid = 1'b1; m_stage = 4;
                        end
                    end
                end
                4: if (root_ready) begin
                       if (m_idx == PU - 1) begin m_valid = 1'b0; m_idx = 0; m_stage = 0; end
                       else m_idx++;
                   end
                default: m_stage = 0;
            endcase
            m_gs = (m_stage != m_prev);
        end
    end

    // Per-decode transcript gathered from the DUT for the transaction-level checks.
    int            q_stage [$];
    int            grow_strobes;
    logic [AW-1:0] roots_seen [$];
    int            idx_seen [$];
    int            last_cnt, last_idx, idx5_cycles;

    always @(negedge clk) begin
        check("stage", 64'(stage), 64'(m_stage));
        check("global_stage", 64'(global_stage), 64'(m_gs));
        check("syndrome_ready", 64'(syndrome_ready), 64'(m_stage == 0));
        check("measurements", 64'(measurements), 64'(m_meas));
        check("iterations", 64'(iterations), 64'(m_iter));
        check("timeout", 64'(timeout), 64'(m_to));
        check("root_valid", 64'(root_valid), 64'(m_valid));
        check("root_index", 64'(root_index), 64'(m_idx));
        check("root_last", 64'(root_last), 64'(m_idx == PU - 1));
        if (m_valid) check("root_data", 64'(root_data), 64'(m_roots[m_idx]));
        if (!reset) begin
            if (stage != 3'd0) q_stage.push_back(int'(stage));
            if (global_stage && stage == 3'd2) grow_strobes++;
            if (root_valid && root_ready) begin
                roots_seen.push_back(root_data);
                idx_seen.push_back(int'(root_index));
                if (root_last) begin last_cnt++; last_idx = int'(root_index); end
            end
            if (root_valid && root_index == 5) idx5_cycles++;
        end
    end

    // scen: 1 zero-syndrome stage trace, 4 busy hold, 5 stall/scramble, 0 generic.
    task automatic run_decode(input logic [PU-1:0] syn, input int t, input int busy_n, input bit rnd_busy,
                              input bit stall5, input bit scramble, input bit rnd_ready, input int scen);
        logic [AW-1:0] pat [PU];
        int busy_cnt = 0;
        int stall_cnt = 0;
        bit seen_report = 1'b0;
        bit done = 1'b0;
        int exp_iter = (t < 1) ? 1 : ((t > MAX_ITER) ? MAX_ITER : t);
        int exp5 [5] = '{1, 2, 3, 3, 4};
        for (int n = 0; n < PU; n++) begin
            pat[n] = AW'($urandom);
            graph_roots[n*AW +: AW] = pat[n];
        end
        q_stage.delete(); roots_seen.delete(); idx_seen.delete();
        grow_strobes = 0; last_cnt = 0; last_idx = -1; idx5_cycles = 0;
        @(posedge clk); #2;
        syndrome = syn; syndrome_valid = 1'b1; graph_busy = 1'b0; graph_odd = 1'b0; root_ready = 1'b1;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            @(posedge clk); #2;
            if (stage == 3'd4) seen_report = 1'b1;
            if (seen_report && stage == 3'd0) begin
                done = 1'b1;
                syndrome_valid = 1'b0;
            end else begin
                syndrome_valid = (stage != 3'd0) ? 1'($urandom) : 1'b0;
                syndrome = PU'($urandom);
                graph_odd = (int'(iterations) < t);
                if (stage == 3'd3 && iterations == 1 && busy_cnt < busy_n) begin
                    graph_busy = 1'b1;
                    busy_cnt++;
                end else graph_busy = rnd_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
                if (scramble && stage == 3'd4)
                    for (int n = 0; n < PU; n++) graph_roots[n*AW +: AW] = AW'($urandom);
                if (stall5 && root_valid && root_index == 5 && stall_cnt < 3) begin
                    root_ready = 1'b0;
                    stall_cnt++;
                end else root_ready = rnd_ready ? 1'($urandom) : 1'b1;
            end
        end
        check("decode_done", 64'(done), 64'(1));
        if (!done) begin
            reset = 1'b1; @(posedge clk); #2; reset = 1'b0;
            return;
        end
        check("final_measurements", 64'(measurements), 64'(syn));
        check("final_iterations", 64'(iterations), 64'(exp_iter));
        check("final_timeout", 64'(timeout), 64'(t > MAX_ITER));
        check("grow_strobes", 64'(grow_strobes), 64'(exp_iter));
        check("root_count", 64'(roots_seen.size()), 64'(PU));
        check("last_count", 64'(last_cnt), 64'(1));
        check("last_index", 64'(last_idx), 64'(PU - 1));
        for (int i = 0; i < roots_seen.size() && i < PU; i++) begin
            check("stream_index", 64'(idx_seen[i]), 64'(i));
            check("stream_root", 64'(roots_seen[i]), 64'(pat[i]));
        end
        if (scen == 1) begin
            check("trace_len_min5", 64'(q_stage.size() >= 5), 64'(1));
            for (int i = 0; i < 5 && i < q_stage.size(); i++) check("zero_syn_stage_seq", 64'(q_stage[i]), 64'(exp5[i]));
        end
        if (scen == 4) begin
            check("trace_len_min14", 64'(q_stage.size() >= 14), 64'(1));
            for (int i = 2; i < 13 && i < q_stage.size(); i++) check("busy_hold_merge", 64'(q_stage[i]), 64'(3));
            if (q_stage.size() >= 14) check("busy_release_grow", 64'(q_stage[13]), 64'(2));
        end
        if (scen == 5) check("stall_hold_idx5", 64'(idx5_cycles), 64'(4));
    endtask

    task automatic reset_mid_merge();
        bit reached = 1'b0;
        @(posedge clk); #2;
        syndrome = PU'($urandom); syndrome_valid = 1'b1; graph_busy = 1'b0; graph_odd = 1'b1; root_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && !reached; cyc++) begin
            @(posedge clk); #2;
            syndrome_valid = 1'b0;
            if (stage == 3'd3 && iterations == 2) reached = 1'b1;
        end
        check("reached_merge_iter2", 64'(reached), 64'(1));
        reset = 1'b1;
        #1;
        check("rst_stage", 64'(stage), 64'(0));
        check("rst_global_stage", 64'(global_stage), 64'(0));
        check("rst_measurements", 64'(measurements), 64'(0));
        check("rst_root_valid", 64'(root_valid), 64'(0));
        check("rst_root_index", 64'(root_index), 64'(0));
        check("rst_iterations", 64'(iterations), 64'(0));
        check("rst_timeout", 64'(timeout), 64'(0));
        check("rst_syndrome_ready", 64'(syndrome_ready), 64'(1));
        @(posedge clk); #2;
        reset = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        check("por_stage", 64'(stage), 64'(0));
        check("por_syndrome_ready", 64'(syndrome_ready), 64'(1));
        check("por_root_valid", 64'(root_valid), 64'(0));
        check("por_iterations", 64'(iterations), 64'(0));

        run_decode('0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        run_decode(PU'($urandom), 3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_decode(PU'($urandom), 100, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_decode(PU'($urandom), 2, 10, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        run_decode(PU'($urandom), 1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 5);
        reset_mid_merge();
        run_decode(PU'($urandom), 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        for (int k = 0; k < 25; k++)
            run_decode(PU'($urandom), int'($urandom_range(0, 18)), 0, 1'($urandom),
                       1'b0, 1'($urandom), 1'($urandom), 0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
